ddram_req_arbiter: RTL and testbench

- Parametrised DDRAM access arbiter on the 50 MHz memory clock. Successor to the fixed CPU/video/loader mux.
- Serves NCH independent read channels plus one loader write port over a single DDRAM command interface.
- Priority is selectable: fixed or round-robin. Each channel has a request/ack handshake with a latched data return.
- Sits between the CPU/video/sample fetch engines (after their clock-domain synchronisers) and the top-level DDRAM pins.

---
 rtl/ddram_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ddram_req_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_req_arbiter.sv
// DDRAM access arbiter: NCH read channels plus one loader write port share one
// command interface. Fixed or round-robin priority; one transaction at a time.
module ddram_req_arbiter #(
   parameter int NCH = 4,
   parameter int AW  = 29,
   parameter int DW  = 64,
   parameter bit RR  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*AW-1:0] ch_addr,
   output logic [NCH-1:0]    ch_ack,
   output logic [DW-1:0]     ch_data,
   input  logic              dl_active,
   input  logic              dl_we,
   input  logic [AW-1:0]     dl_addr,
   input  logic [DW-1:0]     dl_din,
   input  logic [DW/8-1:0]   dl_be,
   output logic              dl_ack,
   output logic              ddram_rd,
   output logic              ddram_we,
   output logic [AW-1:0]     ddram_addr,
   output logic [DW-1:0]     ddram_din,
   output logic [DW/8-1:0]   ddram_be,
   input  logic              ddram_busy,
   input  logic [DW-1:0]     ddram_dout,
   input  logic              ddram_dout_ready,
   output logic [2:0]        grant_id,
   output logic              arb_busy
);

   typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

   state_t           state, state_nx;
   logic [NCH-1:0]   served, elig;
   logic [2*NCH-1:0] rot;
   logic [2:0]       ptr, base, off, pick, ptr_nx;
   logic [3:0]       sum;
   logic             found;
   logic [AW-1:0]    pick_addr, rd_addr, wr_addr;
   logic [DW-1:0]    wr_din;
   logic [DW/8-1:0]  wr_be;
   logic             wr_pend, rd_grant, rd_done, wr_done;

   // Winner search: rotate the eligible set so the search origin sits at bit 0,
   // take the lowest set bit, then rotate the offset back to a channel index.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      elig  = ch_req & ~served;
      base  = RR ? ptr : 3'd0;
      rot   = {elig, elig} >> base;
      found = 1'b0;
      off   = 3'd0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            off   = 3'(j);
         end
      end
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 4'(NCH)) sum = sum - 4'(NCH);
      pick      = sum[2:0];
      pick_addr = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pick == 3'(i)) pick_addr = ch_addr[i*AW +: AW];
      end
      ptr_nx = (pick == 3'(NCH - 1)) ? 3'd0 : pick + 3'd1;
   end

   // A pending or arriving loader write always beats a new read grant.
   always_comb begin
      state_nx = state;
      rd_grant = 1'b0;
      unique case (state)
         IDLE: begin
            if (wr_pend || dl_we) begin
               state_nx = WR_CMD;
            end else if (!dl_active && found) begin
               state_nx = RD_CMD;
               rd_grant = 1'b1;
            end
         end
         RD_CMD:  if (!ddram_busy)       state_nx = RD_WAIT;
         RD_WAIT: if (ddram_dout_ready)  state_nx = IDLE;
         WR_CMD:  if (!ddram_busy)       state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign rd_done = (state == RD_WAIT) && ddram_dout_ready;
   assign wr_done = (state == WR_CMD) && !ddram_busy;

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         served   <= '0;
         ptr      <= '0;
         grant_id <= '0;
         rd_addr  <= '0;
         ch_ack   <= '0;
         ch_data  <= '0;
         dl_ack   <= 1'b0;
         wr_pend  <= 1'b0;
         wr_addr  <= '0;
         wr_din   <= '0;
         wr_be    <= '0;
      end else begin
         ch_ack <= '0;
         dl_ack <= wr_done;
         // A channel becomes eligible again only after it has been seen idle.
         served <= served & ch_req;
         if (rd_grant) begin
            grant_id <= pick;
            rd_addr  <= pick_addr;
            ptr      <= ptr_nx;
         end
         if (rd_done) begin
            ch_data <= ddram_dout;
            for (int i = 0; i < NCH; i++) begin
               if (grant_id == 3'(i)) begin
                  ch_ack[i] <= 1'b1;
                  served[i] <= 1'b1;
               end
            end
         end
         // A later strobe overwrites a write that has not been accepted yet.
         if (dl_we) begin
            wr_pend <= 1'b1;
            wr_addr <= dl_addr;
            wr_din  <= dl_din;
            wr_be   <= dl_be;
         end else if (wr_done) begin
            wr_pend <= 1'b0;
         end
      end
   end

   assign ddram_rd = (state == RD_CMD);
   assign ddram_we = (state == WR_CMD);
   assign arb_busy = (state != IDLE);

   always_comb begin
      ddram_addr = '0;
      ddram_din  = '0;
      ddram_be   = '0;
      if (state == RD_CMD) begin
         ddram_addr = rd_addr;
         ddram_be   = '1;
      end else if (state == WR_CMD) begin
         ddram_addr = wr_addr;
         ddram_din  = wr_din;
         ddram_be   = wr_be;
      end
   end

endmodule

// File: tb/tb_ddram_req_arbiter.sv
// Scoreboard bench for ddram_req_arbiter: a round-robin and a fixed-priority
// instance, each behind a small DDRAM responder model.
module tb_ddram_req_arbiter;
   localparam int NCH = 4;
   localparam int AW  = 29;
   localparam int DW  = 64;
   localparam int BW  = DW / 8;

   typedef struct {int ch; logic [AW-1:0] addr; logic [DW-1:0] data;} rd_exp_t;
   typedef struct {logic [AW-1:0] addr; logic [DW-1:0] din; logic [BW-1:0] be;} wr_exp_t;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   // Index 0: RR=1 instance, index 1: RR=0 instance.
   logic [NCH-1:0]    ch_req   [2];
   logic [NCH*AW-1:0] ch_addr  [2];
   logic [NCH-1:0]    ch_ack   [2];
   logic [DW-1:0]     ch_data  [2];
   logic              dl_active[2];
   logic              dl_we    [2];
   logic [AW-1:0]     dl_addr  [2];
   logic [DW-1:0]     dl_din   [2];
   logic [BW-1:0]     dl_be    [2];
   logic              dl_ack   [2];
   logic              ddram_rd [2];
   logic              ddram_we [2];
   logic [AW-1:0]     ddram_addr[2];
   logic [DW-1:0]     ddram_din[2];
   logic [BW-1:0]     ddram_be [2];
   logic              ddram_busy[2];
   logic [DW-1:0]     ddram_dout[2];
   logic              ddram_dout_ready[2];
   logic [2:0]        grant_id [2];
   logic              arb_busy [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ddram_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR(g == 0 ? 1'b1 : 1'b0)) u_dut (
         .clk(clk), .reset(rst),
         .ch_req(ch_req[g]), .ch_addr(ch_addr[g]), .ch_ack(ch_ack[g]), .ch_data(ch_data[g]),
         .dl_active(dl_active[g]), .dl_we(dl_we[g]), .dl_addr(dl_addr[g]), .dl_din(dl_din[g]),
         .dl_be(dl_be[g]), .dl_ack(dl_ack[g]),
         .ddram_rd(ddram_rd[g]), .ddram_we(ddram_we[g]), .ddram_addr(ddram_addr[g]),
         .ddram_din(ddram_din[g]), .ddram_be(ddram_be[g]), .ddram_busy(ddram_busy[g]),
         .ddram_dout(ddram_dout[g]), .ddram_dout_ready(ddram_dout_ready[g]),
         .grant_id(grant_id[g]), .arb_busy(arb_busy[g]));
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
      if (a == 29'h100) return 64'hDEAD_BEEF_0123_4567;
      return {3'b101, a, 3'b010, ~a};
   endfunction

   // Scoreboard queues
   rd_exp_t rq0[$];
   rd_exp_t rq1[$];
   wr_exp_t wq[$];

   task automatic push_rd(input int k, input int ch, input logic [AW-1:0] a);
      rd_exp_t e;
      e.ch = ch; e.addr = a; e.data = rd_data(a);
      if (k == 0) rq0.push_back(e); else rq1.push_back(e);
   endtask

   function automatic int q_size(input int k);
      return (k == 0) ? rq0.size() : rq1.size();
   endfunction

   // DDRAM responder: busy_cfg stall cycles per command, rsp_lat cycles to return
   int            busy_cfg[2];
   int            rsp_lat [2];
   int            busy_left[2];
   int            rsp_wait[2];
   logic [DW-1:0] rsp_data[2];
   logic          prev_cmd[2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         ddram_busy[k] = 1'b0; ddram_dout[k] = '0; ddram_dout_ready[k] = 1'b0;
         busy_left[k] = 0; rsp_wait[k] = 0; rsp_data[k] = '0; prev_cmd[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            ddram_dout_ready[k] = 1'b0;
            if (rsp_wait[k] > 0) begin
               rsp_wait[k]--;
               if (rsp_wait[k] == 0) begin
                  ddram_dout_ready[k] = 1'b1;
                  ddram_dout[k]       = rsp_data[k];
               end
            end
            if (ddram_rd[k] || ddram_we[k]) begin
               if (!prev_cmd[k]) busy_left[k] = busy_cfg[k];
               if (busy_left[k] > 0) begin
                  ddram_busy[k] = 1'b1;
                  busy_left[k]--;
               end else begin
                  ddram_busy[k] = 1'b0;
                  if (ddram_rd[k]) begin
                     rsp_wait[k] = rsp_lat[k];
                     rsp_data[k] = rd_data(ddram_addr[k]);
                  end
               end
            end else begin
               ddram_busy[k] = 1'b0;
            end
            prev_cmd[k] = ddram_rd[k] || ddram_we[k];
         end
      end
   end

   // Monitor: checks command addresses, acks and writes against the queues
   int   cyc = 0;
   int   rd_cycles[2], rd_bursts[2], ack_cnt[2];
   int   dlack_cnt = 0, last_ack_cyc = 0, last_we_cyc = 0;
   logic prev_rd[2];
   logic prev_we = 1'b0;

   initial begin
      rd_exp_t e;
      for (int k = 0; k < 2; k++) begin
         rd_cycles[k] = 0; rd_bursts[k] = 0; ack_cnt[k] = 0; prev_rd[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (ddram_rd[k]) begin
               rd_cycles[k]++;
               if (!prev_rd[k]) begin
                  rd_bursts[k]++;
                  if (q_size(k) == 0) begin
                     check("rd_unexpected", 1, 0);
                  end else begin
                     e = (k == 0) ? rq0[0] : rq1[0];
                     check("rd_addr", 64'(ddram_addr[k]), 64'(e.addr));
                     check("rd_be", 64'(ddram_be[k]), 64'hFF);
                  end
               end
            end
            prev_rd[k] = ddram_rd[k];
            if (ch_ack[k] != '0) begin
               ack_cnt[k]++;
               last_ack_cyc = cyc;
               if (q_size(k) == 0) begin
                  check("ack_unexpected", 64'(ch_ack[k]), 0);
               end else begin
                  e = (k == 0) ? rq0.pop_front() : rq1.pop_front();
                  check("ack_vec", 64'(ch_ack[k]), 64'(1) << e.ch);
                  check("ack_data", ch_data[k], e.data);
                  check("grant_id", 64'(grant_id[k]), 64'(e.ch));
               end
            end
         end
         if (ddram_we[0] && !prev_we) begin
            last_we_cyc = cyc;
            if (wq.size() == 0) begin
               check("we_unexpected", 1, 0);
            end else begin
               check("wr_addr", 64'(ddram_addr[0]), 64'(wq[0].addr));
               check("wr_din", ddram_din[0], wq[0].din);
               check("wr_be", 64'(ddram_be[0]), 64'(wq[0].be));
            end
         end
         prev_we = ddram_we[0];
         if (dl_ack[0]) begin
            dlack_cnt++;
            if (wq.size() != 0) void'(wq.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack(input int k, input string tag, output int ch);
      ch = -1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ch_ack[k] != '0) begin
            for (int i = 0; i < NCH; i++) if (ch_ack[k][i]) ch = i;
            return;
         end
      end
      check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_rd(input int k, input string tag);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ddram_rd[k]) return;
      end
      check({tag, "_timeout"}, 0, 1);
   endtask

   // Serve one read on instance k and drop the request as soon as it is acked.
   task automatic serve(input int k, input string tag);
      int ch;
      wait_ack(k, tag, ch);
      if (ch >= 0) ch_req[k][ch] = 1'b0;
   endtask

   function automatic logic [AW-1:0] ch_base(input int i);
      return AW'(29'h1000 + i * 29'h40);
   endfunction

   initial begin
      int ch, s0, s1, s2;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         ch_req[k] = '0; ch_addr[k] = '0; dl_active[k] = 1'b0; dl_we[k] = 1'b0;
         dl_addr[k] = '0; dl_din[k] = '0; dl_be[k] = '0;
         busy_cfg[k] = 0; rsp_lat[k] = 5;
         for (int i = 0; i < NCH; i++) ch_addr[k][i*AW +: AW] = ch_base(i);
      end
      tick(2);
      check("rst_ctrl", 64'({ddram_rd[0], ddram_we[0], ch_ack[0], dl_ack[0], grant_id[0],
                             arb_busy[0], ddram_be[0]}), 0);
      check("rst_addr", 64'(ddram_addr[0]), 0);
      check("rst_data", ch_data[0], 0);
      rst = 1'b0;
      tick(2);

      // Round-robin: all four held and re-raised one cycle after each ack
      push_rd(0, 0, ch_base(0)); push_rd(0, 1, ch_base(1)); push_rd(0, 2, ch_base(2));
      push_rd(0, 3, ch_base(3)); push_rd(0, 0, ch_base(0));
      ch_req[0] = 4'hF;
      for (int n = 0; n < 5; n++) begin
         wait_ack(0, "rr_order", ch);
         if (n == 4) begin
            ch_req[0] = '0;
         end else if (ch >= 0) begin
            ch_req[0][ch] = 1'b0;
            tick(1);
            ch_req[0][ch] = 1'b1;
         end
      end
      tick(3);

      // Single read, latency and held data
      ch_addr[0][2*AW +: AW] = 29'h100;
      push_rd(0, 2, 29'h100);
      s0 = rd_cycles[0];
      ch_req[0][2] = 1'b1;
      tick(1);
      check("lat_rd", 64'(ddram_rd[0]), 1);
      check("lat_gid", 64'(grant_id[0]), 2);
      check("lat_busy", 64'(arb_busy[0]), 1);
      serve(0, "single");
      tick(3);
      check("single_rd_cycles", 64'(rd_cycles[0] - s0), 1);
      check("data_hold", ch_data[0], 64'hDEAD_BEEF_0123_4567);

      // Fixed priority: channel 0 re-requests after one low cycle
      for (int n = 0; n < 3; n++) begin
         push_rd(1, 0, ch_base(0));
         ch_req[1][0] = 1'b1;
         serve(1, "fx_ch0");
         tick(1);
      end
      push_rd(1, 1, ch_base(1)); push_rd(1, 3, ch_base(3));
      ch_req[1] = 4'b1010;
      serve(1, "fx_low");
      serve(1, "fx_high");
      tick(2);

      // Command stall: busy for 7 cycles
      busy_cfg[0] = 7;
      push_rd(0, 1, ch_base(1));
      s0 = rd_cycles[0]; s1 = rd_bursts[0]; s2 = ack_cnt[0];
      ch_req[0][1] = 1'b1;
      serve(0, "stall");
      tick(2);
      busy_cfg[0] = 0;
      check("stall_rd_cycles", 64'(rd_cycles[0] - s0), 8);
      check("stall_bursts", 64'(rd_bursts[0] - s1), 1);
      check("stall_acks", 64'(ack_cnt[0] - s2), 1);

      // Loader write arriving while a read is in flight
      push_rd(0, 3, ch_base(3));
      wq.push_back('{addr: 29'h0AB_CDE, din: 64'h1122_3344_5566_7788, be: 8'h0C});
      s0 = dlack_cnt;
      ch_req[0][3] = 1'b1;
      wait_rd(0, "wr_mid_rd");
      tick(2);
      dl_we[0] = 1'b1; dl_addr[0] = 29'h0AB_CDE; dl_din[0] = 64'h1122_3344_5566_7788; dl_be[0] = 8'h0C;
      tick(1);
      dl_we[0] = 1'b0; dl_addr[0] = '0; dl_din[0] = '0; dl_be[0] = '0;
      serve(0, "wr_mid_ack");
      for (int n = 0; n < 30 && dlack_cnt == s0; n++) tick(1);
      tick(3);
      check("dl_ack_count", 64'(dlack_cnt - s0), 1);
      check("wr_after_rd", 64'(last_we_cyc > last_ack_cyc), 1);

      // Download in progress blocks new reads
      dl_active[0] = 1'b1;
      push_rd(0, 1, ch_base(1));
      s1 = rd_bursts[0];
      ch_req[0][1] = 1'b1;
      tick(10);
      check("dl_block", 64'(rd_bursts[0] - s1), 0);
      dl_active[0] = 1'b0;
      tick(1);
      check("dl_release_rd", 64'(ddram_rd[0]), 1);
      serve(0, "dl_release");
      tick(2);

      // Asynchronous reset while waiting for read data
      push_rd(0, 3, ch_base(3));
      ch_req[0][3] = 1'b1;
      wait_rd(0, "rst_mid");
      tick(2);
      #3 rst = 1'b1;
      #1;
      check("rst_mid_ctrl", 64'({ddram_rd[0], arb_busy[0], ch_ack[0], ddram_be[0]}), 0);
      check("rst_mid_addr", 64'(ddram_addr[0]), 0);
      check("rst_mid_data", ch_data[0], 0);
      if (rq0.size() != 0) void'(rq0.pop_back());
      ch_req[0] = '0;
      tick(1);
      rst = 1'b0;
      s2 = ack_cnt[0];
      tick(10);
      check("late_return_ignored", 64'(ack_cnt[0] - s2), 0);
      push_rd(0, 2, ch_base(2));
      ch_addr[0][2*AW +: AW] = ch_base(2);
      ch_req[0][2] = 1'b1;
      serve(0, "post_rst");
      tick(3);
      check("post_rst_acks", 64'(ack_cnt[0] - s2), 1);

      check("rd_queues_empty", 64'(rq0.size() + rq1.size()), 0);
      check("wr_queue_empty", 64'(wq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
      $fatal(1);
   end

endmodule
